// File: rtl/grid_move_writer_pkg.sv
// Shared definitions for the tic-tac-toe move writer: cell/result codes, FSM states, win lines.
// Latency: none (constants and a combinational helper only).
// Backpressure: not applicable.
package grid_move_writer_pkg;

  localparam int NUM_CELLS = 9;
  localparam int CODE_W    = 2;
  localparam int GRID_W    = NUM_CELLS * CODE_W;

  // Cell codes as stored in the packed grid
  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_O     = 2'd1;
  localparam logic [1:0] CELL_X     = 2'd2;

  // Result codes reported on winner
  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_O    = 2'd1;
  localparam logic [1:0] WIN_X    = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WRITE,
    EVAL,
    OVER
  } state_e;

  // Rows, columns, then the two diagonals (cell indices, row-major from top-left)
  localparam logic [3:0] WIN_LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Cell k lives at bits [GRID_W-1-2k : GRID_W-2-2k]; indices past the board read as empty
  function automatic logic [1:0] cell_at(input logic [GRID_W-1:0] g, input logic [3:0] idx);
    cell_at = CELL_EMPTY;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (idx == 4'(k)) cell_at = g[(NUM_CELLS-1-k)*CODE_W +: CODE_W];
    end
  endfunction

endpackage

// File: rtl/grid_move_writer_win_checker.sv
// Scans all eight lines of the board and reports which player owns a complete line.
// Latency: purely combinational.
// Backpressure: not applicable.
module grid_win_checker
  import grid_move_writer_pkg::*;
(
  input  logic [GRID_W-1:0] grid_i,
  output logic [1:0]        line_win_o
);

  logic [1:0] a, b, c;

  // A line wins when its three cells hold the same non-empty code
  always_comb begin
    line_win_o = WIN_NONE;
    a = CELL_EMPTY;
    b = CELL_EMPTY;
    c = CELL_EMPTY;
    for (int l = 0; l < 8; l++) begin
      a = cell_at(grid_i, WIN_LINES[l][0]);
      b = cell_at(grid_i, WIN_LINES[l][1]);
      c = cell_at(grid_i, WIN_LINES[l][2]);
      if (a != CELL_EMPTY && a == b && b == c) line_win_o = a;
    end
  end

endmodule

// File: rtl/grid_move_writer.sv
// Validates a move, writes it into the packed board, pulses the renderer and scores the game.
// Latency: place at edge N -> move_err after N+1, grid/draw_req after N+2, turn/winner after N+3.
// Backpressure: none; place outside IDLE is dropped, busy tells the source when it will be taken.
module grid_move_writer
  import grid_move_writer_pkg::*;
#(
  parameter int CELLS  = 9,
  parameter int CELL_W = 2
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [3:0]              cell_sel,
  input  logic                    place,
  input  logic                    new_game,
  output logic [CELLS*CELL_W-1:0] grid,
  output logic                    turn,
  output logic [1:0]              winner,
  output logic                    game_over,
  output logic                    draw_req,
  output logic [3:0]              draw_cell,
  output logic                    move_err,
  output logic                    busy
);

  localparam int GW = CELLS * CELL_W;

  state_e            state_q, state_d;
  logic [GW-1:0]     grid_q, grid_d;
  logic [3:0]        sel_q, sel_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        draw_cell_q, draw_cell_d;
  logic              turn_q, turn_d;
  logic              draw_req_q, draw_req_d;
  logic              move_err_q, move_err_d;
  logic [1:0]        winner_q, winner_d;
  logic [1:0]        line_win;
  logic              sel_taken;
  logic [CELL_W-1:0] move_code;

  grid_win_checker u_win_checker (
    .grid_i     (grid_q),
    .line_win_o (line_win)
  );

  // X writes code 2, O writes code 1; code 3 is never produced
  assign move_code = turn_q ? CELL_W'(CELL_X) : CELL_W'(CELL_O);

  // Occupancy of the selected cell; out-of-range indices are caught by the range test instead
  always_comb begin
    sel_taken = 1'b0;
    for (int k = 0; k < CELLS; k++) begin
      if (sel_q == 4'(k) && grid_q[(CELLS-1-k)*CELL_W +: CELL_W] != '0) sel_taken = 1'b1;
    end
  end

  // Move sequencing; new_game overrides whatever the current state decided
  always_comb begin
    state_d     = state_q;
    grid_d      = grid_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    turn_d      = turn_q;
    winner_d    = winner_q;
    draw_cell_d = draw_cell_q;
    draw_req_d  = 1'b0;
    move_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (place) begin
          sel_d   = cell_sel;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (int'(sel_q) >= CELLS || sel_taken) begin
          move_err_d = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        for (int k = 0; k < CELLS; k++) begin
          if (sel_q == 4'(k)) grid_d[(CELLS-1-k)*CELL_W +: CELL_W] = move_code;
        end
        cnt_d       = cnt_q + 4'd1;
        draw_req_d  = 1'b1;
        draw_cell_d = sel_q;
        state_d     = EVAL;
      end
      EVAL: begin
        // A completed line beats a full board, so a winning ninth move is not a tie
        if (line_win != WIN_NONE) begin
          winner_d = line_win;
          state_d  = OVER;
        end else if (cnt_q == 4'(CELLS)) begin
          winner_d = WIN_TIE;
          state_d  = OVER;
        end else begin
          turn_d  = ~turn_q;
          state_d = IDLE;
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (new_game) begin
      grid_d     = '0;
      cnt_d      = 4'd0;
      winner_d   = WIN_NONE;
      turn_d     = 1'b0;
      state_d    = IDLE;
      draw_req_d = 1'b0;
      move_err_d = 1'b0;
    end
  end

  // State and output registers; reset abandons any move in flight
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      grid_q      <= '0;
      sel_q       <= 4'd0;
      cnt_q       <= 4'd0;
      turn_q      <= 1'b0;
      winner_q    <= WIN_NONE;
      draw_cell_q <= 4'd0;
      draw_req_q  <= 1'b0;
      move_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grid_q      <= grid_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      turn_q      <= turn_d;
      winner_q    <= winner_d;
      draw_cell_q <= draw_cell_d;
      draw_req_q  <= draw_req_d;
      move_err_q  <= move_err_d;
    end
  end

  assign grid      = grid_q;
  assign turn      = turn_q;
  assign winner    = winner_q;
  assign game_over = (state_q == OVER);
  assign draw_req  = draw_req_q;
  assign draw_cell = draw_cell_q;
  assign move_err  = move_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_grid_move_writer.sv
// Directed bench for grid_move_writer with a timeline model of each move.
// Latency: model schedules err at +1, write/draw at +2, result at +3 edges after acceptance.
// Backpressure: stimulus only issues place; the model drops it when a move is in flight or the game is over.
module tb_grid_move_writer;

  logic        clock    = 1'b0;
  logic        resetn   = 1'b0;
  logic        place    = 1'b0;
  logic        new_game = 1'b0;
  logic [3:0]  cell_sel = 4'd0;
  logic [17:0] grid;
  logic        turn, game_over, draw_req, move_err, busy;
  logic [1:0]  winner;
  logic [3:0]  draw_cell;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  grid_move_writer #(.CELLS(9), .CELL_W(2)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .cell_sel  (cell_sel),
    .place     (place),
    .new_game  (new_game),
    .grid      (grid),
    .turn      (turn),
    .winner    (winner),
    .game_over (game_over),
    .draw_req  (draw_req),
    .draw_cell (draw_cell),
    .move_err  (move_err),
    .busy      (busy)
  );

  // ---------------- model: board array plus one pending move with an age ----------------
  int m_board [16];
  int m_turn   = 0;
  int m_winner = 0;
  int m_moves  = 0;
  bit m_over   = 1'b0;
  bit e_draw   = 1'b0;
  bit e_err    = 1'b0;
  int e_dcell  = 0;
  int pend_t   = -1;
  int pend_cell = 0;
  bit pend_ok  = 1'b0;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic int line_winner();
    for (int l = 0; l < 8; l++) begin
      if (m_board[lines[l][0]] != 0 &&
          m_board[lines[l][0]] == m_board[lines[l][1]] &&
          m_board[lines[l][1]] == m_board[lines[l][2]])
        return m_board[lines[l][0]];
    end
    return 0;
  endfunction

  function automatic int pack_grid();
    int g = 0;
    for (int k = 0; k < 9; k++) g = g + (m_board[k] << (16 - 2*k));
    return g;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 16; k++) m_board[k] = 0;
    m_turn = 0; m_winner = 0; m_moves = 0; m_over = 1'b0;
    e_draw = 1'b0; e_err = 1'b0; pend_t = -1;
  endtask

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      model_clear();
    end else begin
      e_draw = 1'b0;
      e_err  = 1'b0;
      if (new_game) begin
        model_clear();
      end else begin
        if (pend_t >= 0) pend_t = pend_t + 1;
        if (pend_t == 1 && !pend_ok) begin
          e_err  = 1'b1;
          pend_t = -1;
        end else if (pend_t == 2) begin
          m_board[pend_cell] = (m_turn != 0) ? 2 : 1;
          m_moves = m_moves + 1;
          e_draw  = 1'b1;
          e_dcell = pend_cell;
        end else if (pend_t == 3) begin
          if (line_winner() != 0) begin
            m_winner = line_winner();
            m_over   = 1'b1;
          end else if (m_moves == 9) begin
            m_winner = 3;
            m_over   = 1'b1;
          end else begin
            m_turn = 1 - m_turn;
          end
          pend_t = -1;
        end else if (pend_t < 0 && !m_over && place) begin
          pend_t    = 0;
          pend_cell = int'(cell_sel);
          pend_ok   = (cell_sel < 4'd9) && (m_board[cell_sel] == 0);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- compare process: every cycle, away from the rising edge ----------------
  always @(negedge clock) begin
    check("grid",      int'(grid),      pack_grid());
    check("turn",      int'(turn),      m_turn);
    check("winner",    int'(winner),    m_winner);
    check("game_over", int'(game_over), int'(m_over));
    check("draw_req",  int'(draw_req),  int'(e_draw));
    check("move_err",  int'(move_err),  int'(e_err));
    check("busy",      int'(busy),      int'(pend_t >= 0 || m_over));
    if (e_draw) check("draw_cell", int'(draw_cell), e_dcell);
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_place(input int c);
    @(negedge clock);
    cell_sel = 4'(c);
    place    = 1'b1;
    @(negedge clock);
    place    = 1'b0;
  endtask

  task automatic pulse_new_game();
    @(negedge clock);
    new_game = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
  endtask

  task automatic play(input int c);
    pulse_place(c);
    idle(4);
  endtask

  initial begin
    // reset state
    idle(2);
    check("rst_grid", int'(grid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_draw_cell", int'(draw_cell), 0);
    #2 resetn = 1'b1;
    idle(2);

    // O takes the centre: grid two cycles later, draw pulse, then X to move
    pulse_place(4);
    check("c4_busy", int'(busy), 1);
    idle(1);
    check("c4_grid_early", int'(grid), 0);
    idle(1);
    check("c4_grid", int'(grid), 'h00100);
    check("c4_draw_req", int'(draw_req), 1);
    check("c4_draw_cell", int'(draw_cell), 4);
    idle(1);
    check("c4_turn", int'(turn), 1);
    check("c4_draw_end", int'(draw_req), 0);
    idle(2);

    // X tries the occupied centre
    pulse_place(4);
    idle(1);
    check("occ_err", int'(move_err), 1);
    idle(1);
    check("occ_err_end", int'(move_err), 0);
    check("occ_grid", int'(grid), 'h00100);
    check("occ_turn", int'(turn), 1);
    idle(2);

    // Out-of-range cell index
    pulse_place(11);
    idle(1);
    check("oor_err", int'(move_err), 1);
    idle(1);
    check("oor_no_draw", int'(draw_req), 0);
    check("oor_grid", int'(grid), 'h00100);
    idle(2);

    // O wins on the top row
    pulse_new_game();
    check("ng_grid", int'(grid), 0);
    check("ng_turn", int'(turn), 0);
    play(0); play(3); play(1); play(4); play(2);
    check("row_winner", int'(winner), 1);
    check("row_over", int'(game_over), 1);
    check("row_grid", int'(grid), 'h15A00);
    play(5);
    check("over_grid_held", int'(grid), 'h15A00);
    check("over_winner_held", int'(winner), 1);

    // Full board without a line
    pulse_new_game();
    play(0); play(1); play(2); play(4); play(3); play(5); play(7); play(6);
    check("tie_pre_winner", int'(winner), 0);
    check("tie_pre_over", int'(game_over), 0);
    play(8);
    check("tie_winner", int'(winner), 3);
    check("tie_over", int'(game_over), 1);
    check("tie_grid", int'(grid), 'h196A5);

    // new_game together with place while the DUT is in CHECK
    pulse_new_game();
    play(0);
    pulse_place(2);
    new_game = 1'b1;
    place    = 1'b1;
    cell_sel = 4'd5;
    @(negedge clock);
    new_game = 1'b0;
    place    = 1'b0;
    check("ngchk_grid", int'(grid), 0);
    check("ngchk_turn", int'(turn), 0);
    check("ngchk_busy", int'(busy), 0);
    check("ngchk_draw", int'(draw_req), 0);
    idle(3);
    check("ngchk_grid_late", int'(grid), 0);

    // Reset pulsed while the DUT is in WRITE
    play(0);
    pulse_place(4);
    idle(1);
    #2 resetn = 1'b0;
    #1;
    check("rstw_grid", int'(grid), 0);
    check("rstw_turn", int'(turn), 0);
    check("rstw_winner", int'(winner), 0);
    check("rstw_over", int'(game_over), 0);
    check("rstw_draw", int'(draw_req), 0);
    check("rstw_draw_cell", int'(draw_cell), 0);
    check("rstw_err", int'(move_err), 0);
    check("rstw_busy", int'(busy), 0);

    // First place right after release is taken
    @(negedge clock);
    #2;
    resetn   = 1'b1;
    cell_sel = 4'd6;
    place    = 1'b1;
    @(negedge clock);
    place    = 1'b0;
    idle(2);
    check("post_rst_grid", int'(grid), 'h00010);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
